// File: rtl/ptmch_pkg.sv
// ptmch_pkg: shared types and constants for the SPI-NAND opcode snooper.
//   ptmch_snoop_st_t : snooper FSM state encoding
//   opcode constants : common SPI-NAND command opcodes
//   cnt_width()      : bits needed to hold values 0..max_val
package ptmch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } ptmch_snoop_st_t;

  localparam logic [7:0] PROGRAM_EXECUTE  = 8'h10;
  localparam logic [7:0] READ_STATUS1     = 8'h0F;
  localparam logic [7:0] READ_STATUS2     = 8'h05;
  localparam logic [7:0] BLOCK_ERASE_128K = 8'hD8;
  localparam logic [7:0] PAGE_DATA_READ   = 8'h13;
  localparam logic [7:0] WRITE_STATUS1    = 8'h1F;
  localparam logic [7:0] WRITE_STATUS2    = 8'h01;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/ptmch_pls_stretch.sv
// ptmch_pls_stretch: retriggerable pulse stretcher for one trigger channel.
//   CLK160M : system clock
//   RESET_N : asynchronous active-low reset
//   HIT     : one-cycle hit; (re)loads the pulse length
//   PLS     : high for PLS_LEN cycles after the last HIT
module ptmch_pls_stretch
  import ptmch_pkg::*;
#(
  parameter int unsigned PLS_LEN = 15
) (
  input  logic CLK160M,
  input  logic RESET_N,
  input  logic HIT,
  output logic PLS
);

  localparam int unsigned CW = cnt_width(PLS_LEN);

  logic [CW-1:0] cnt_q;

  // Down-counter, saturating at zero; a hit always reloads so a retrigger
  // extends the pulse without a low gap.
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (HIT) begin
      cnt_q <= CW'(PLS_LEN);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign PLS = (cnt_q != '0);

endmodule

// File: rtl/ptmch_snoop_trg.sv
// ptmch_snoop_trg: oversampling SPI-NAND opcode snooper with per-channel
// match/mask trigger pulses. Everything runs on CLK160M.
//   CLK160M   : system clock
//   RESET_N   : asynchronous active-low reset
//   SPI_CS    : chip select (active-low, asynchronous)
//   SPI_CLK   : SPI clock (asynchronous, <= CLK160M/4)
//   SPI_MOSI  : SPI data (asynchronous)
//   CFG_EDGE  : sampling edge, 0 = rising, 1 = falling
//   CFG_EN    : per-channel enable
//   CFG_MATCH : per-channel opcode, channel i at [i*OPC_W +: OPC_W]
//   CFG_MASK  : per-channel compare mask, 1 = compared
//   TRG_PLS   : per-channel trigger pulse
//   OPC_VLD   : one-cycle strobe, opcode captured
//   OPC_DATA  : last captured opcode
//   SHORT_ERR : one-cycle strobe, CS rose before a full opcode
//
// state | meaning
// IDLE  | waiting for CS fall
// SHIFT | CS low, collecting opcode bits
// HOLD  | opcode captured, ignoring address/data until CS rise
module ptmch_snoop_trg
  import ptmch_pkg::*;
#(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned OPC_W    = 8,
  parameter int unsigned PLS_LEN  = 15,
  parameter int unsigned SYNC_STG = 3
) (
  input  logic                      CLK160M,
  input  logic                      RESET_N,
  input  logic                      SPI_CS,
  input  logic                      SPI_CLK,
  input  logic                      SPI_MOSI,
  input  logic                      CFG_EDGE,
  input  logic [NUM_CH-1:0]         CFG_EN,
  input  logic [NUM_CH*OPC_W-1:0]   CFG_MATCH,
  input  logic [NUM_CH*OPC_W-1:0]   CFG_MASK,
  output logic [NUM_CH-1:0]         TRG_PLS,
  output logic                      OPC_VLD,
  output logic [OPC_W-1:0]          OPC_DATA,
  output logic                      SHORT_ERR
);

  localparam int unsigned BCW = cnt_width(OPC_W);

  // ---------------- synchronisers and edge detect ----------------
  logic [SYNC_STG-1:0] cs_sync, clk_sync, mosi_sync;
  logic                cs_d, clk_d;
  logic                cs_s, clk_s, mosi_s;
  logic [SYNC_STG:0]   flush_sr;
  logic                armed_q;

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      clk_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STG-2:0], SPI_CS};
      clk_sync  <= {clk_sync[SYNC_STG-2:0], SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], SPI_MOSI};
      cs_d      <= cs_s;
      clk_d     <= clk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STG-1];
  assign clk_s  = clk_sync[SYNC_STG-1];
  assign mosi_s = mosi_sync[SYNC_STG-1];

  // The CS chain resets to 1, so a CS already low at reset release would
  // otherwise look like a fresh fall. Only arm once the chain has been
  // flushed with real pin samples and CS has actually been seen high.
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      flush_sr <= '0;
      armed_q  <= 1'b0;
    end else begin
      flush_sr <= {flush_sr[SYNC_STG-1:0], 1'b1};
      if (flush_sr[SYNC_STG] && cs_d) armed_q <= 1'b1;
    end
  end

  logic edge_sh;
  logic cs_fall, cs_rise, smp_edge;

  assign cs_fall  = armed_q & cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign smp_edge = edge_sh ? (clk_d & ~clk_s) : (~clk_d & clk_s);

  // ---------------- FSM ----------------
  ptmch_snoop_st_t st_q, st_nxt;
  logic [BCW-1:0]  bit_cnt_q;
  logic            ld_shadow, do_shift, do_cap, do_short;

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) st_q <= IDLE;
    else          st_q <= st_nxt;
  end

  always_comb begin
    st_nxt    = st_q;
    ld_shadow = 1'b0;
    do_shift  = 1'b0;
    do_cap    = 1'b0;
    do_short  = 1'b0;
    case (st_q)
      IDLE: begin
        if (cs_fall) begin
          ld_shadow = 1'b1;
          st_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_fall) begin
          ld_shadow = 1'b1;
          st_nxt    = SHIFT;
        end else begin
          // A sampling edge coincident with CS rise is consumed first.
          if (smp_edge) begin
            do_shift = 1'b1;
            if (bit_cnt_q == BCW'(OPC_W - 1)) begin
              do_cap = 1'b1;
              st_nxt = cs_rise ? IDLE : HOLD;
            end
          end
          if (cs_rise && !do_cap) begin
            do_short = 1'b1;
            st_nxt   = IDLE;
          end
        end
      end
      HOLD: begin
        if (cs_fall) begin
          ld_shadow = 1'b1;
          st_nxt    = SHIFT;
        end else if (cs_rise) begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Only OPC_W-1 bits need storing: the last bit comes straight from MOSI.
  logic [OPC_W-2:0]        sh_q;
  logic [OPC_W-1:0]        opc_q;
  logic                    opc_vld_q, short_q;
  logic [NUM_CH-1:0]       en_sh;
  logic [NUM_CH*OPC_W-1:0] match_sh, mask_sh;

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      opc_q     <= '0;
      opc_vld_q <= 1'b0;
      short_q   <= 1'b0;
      en_sh     <= '0;
      match_sh  <= '0;
      mask_sh   <= '0;
      edge_sh   <= 1'b0;
    end else begin
      opc_vld_q <= do_cap;
      short_q   <= do_short;
      if (ld_shadow) begin
        bit_cnt_q <= '0;
        sh_q      <= '0;
        en_sh     <= CFG_EN;
        match_sh  <= CFG_MATCH;
        mask_sh   <= CFG_MASK;
        edge_sh   <= CFG_EDGE;
      end else if (do_shift) begin
        bit_cnt_q <= bit_cnt_q + BCW'(1);
        sh_q      <= {sh_q[OPC_W-3:0], mosi_s};
      end
      if (do_cap) opc_q <= {sh_q, mosi_s};
    end
  end

  assign OPC_VLD   = opc_vld_q;
  assign OPC_DATA  = opc_q;
  assign SHORT_ERR = short_q;

  // ---------------- match and pulse stretch ----------------
  logic [NUM_CH-1:0] hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = opc_vld_q & en_sh[i] &
                    ~|((opc_q ^ match_sh[i*OPC_W +: OPC_W]) & mask_sh[i*OPC_W +: OPC_W]);

    ptmch_pls_stretch #(
      .PLS_LEN (PLS_LEN)
    ) u_stretch (
      .CLK160M (CLK160M),
      .RESET_N (RESET_N),
      .HIT     (hit[i]),
      .PLS     (TRG_PLS[i])
    );
  end

endmodule

// File: tb/tb_ptmch_snoop_trg.sv
`timescale 1ns/1ps
module tb_ptmch_snoop_trg;
  import ptmch_pkg::*;

  localparam int NCH = 5;
  localparam int OW  = 8;
  localparam int PL  = 15;
  localparam int PLL = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              spi_cs, spi_clk, spi_mosi, cfg_edge;
  logic [NCH-1:0]    cfg_en;
  logic [NCH*OW-1:0] cfg_match, cfg_mask;
  logic [NCH-1:0]    trg, trg_l;
  logic              opc_vld, opc_vld_l, short_err, short_err_l;
  logic [OW-1:0]     opc_data, opc_data_l;

  ptmch_snoop_trg #(.NUM_CH(NCH), .OPC_W(OW), .PLS_LEN(PL), .SYNC_STG(3)) dut (
    .CLK160M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk),
    .SPI_MOSI(spi_mosi), .CFG_EDGE(cfg_edge), .CFG_EN(cfg_en),
    .CFG_MATCH(cfg_match), .CFG_MASK(cfg_mask), .TRG_PLS(trg),
    .OPC_VLD(opc_vld), .OPC_DATA(opc_data), .SHORT_ERR(short_err));

  // Long-pulse instance: lets a back-to-back retrigger land inside the pulse.
  ptmch_snoop_trg #(.NUM_CH(NCH), .OPC_W(OW), .PLS_LEN(PLL), .SYNC_STG(3)) dut_l (
    .CLK160M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk),
    .SPI_MOSI(spi_mosi), .CFG_EDGE(cfg_edge), .CFG_EN(cfg_en),
    .CFG_MATCH(cfg_match), .CFG_MASK(cfg_mask), .TRG_PLS(trg_l),
    .OPC_VLD(opc_vld_l), .OPC_DATA(opc_data_l), .SHORT_ERR(short_err_l));

  typedef struct {
    logic [OW-1:0]  opc;
    logic [NCH-1:0] hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int short_exp = 0;
  int short_seen = 0;
  int short_seen_l = 0;
  int half = 4;
  int cnt_m[NCH];
  int cnt_l[NCH];
  logic [NCH-1:0] m_out, l_out;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      cnt_m[i] = 0;
      cnt_l[i] = 0;
    end
  end

  // Scoreboard/monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_m[i] = 0;
        cnt_l[i] = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      m_out[i] = (cnt_m[i] != 0);
      l_out[i] = (cnt_l[i] != 0);
    end
    total++;
    assert (trg === m_out) else begin
      bad++; $error("FAIL trg got=%b exp=%b t=%0t", trg, m_out, $time);
    end
    total++;
    assert (trg_l === l_out) else begin
      bad++; $error("FAIL trg_long got=%b exp=%b t=%0t", trg_l, l_out, $time);
    end
    if (short_err === 1'b1) short_seen++;
    if (short_err_l === 1'b1) short_seen_l++;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_m[i] > 0) cnt_m[i]--;
      if (cnt_l[i] > 0) cnt_l[i]--;
    end
    if (opc_vld === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++; $error("FAIL unexpected_vld got=%h exp=none t=%0t", opc_data, $time);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (opc_data === e.opc) else begin
          bad++; $error("FAIL opc_data got=%h exp=%h", opc_data, e.opc);
        end
        total++;
        assert (opc_data_l === e.opc) else begin
          bad++; $error("FAIL opc_data_long got=%h exp=%h", opc_data_l, e.opc);
        end
        total++;
        assert (opc_vld_l === 1'b1) else begin
          bad++; $error("FAIL opc_vld_long got=%b exp=1", opc_vld_l);
        end
        for (int i = 0; i < NCH; i++) begin
          if (e.hit[i]) begin
            cnt_m[i] = PL;
            cnt_l[i] = PLL;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input logic en, input logic [OW-1:0] m, input logic [OW-1:0] k);
    cfg_en[ch] = en;
    cfg_match[ch*OW +: OW] = m;
    cfg_mask[ch*OW +: OW] = k;
  endtask

  task automatic push(input logic [OW-1:0] opc, input logic [NCH-1:0] hit);
    exp_t x;
    x.opc = opc;
    x.hit = hit;
    exp_q.push_back(x);
  endtask

  task automatic spi_begin();
    spi_cs = 1'b0;
    cyc(half);
  endtask

  // Toggling away from the idle level is the sampling edge in both modes.
  task automatic spi_bits(input logic [31:0] d, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      spi_mosi = d[b];
      cyc(half);
      spi_clk = ~cfg_edge;
      cyc(half);
      spi_clk = cfg_edge;
    end
  endtask

  task automatic spi_end();
    cyc(half);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    cyc(half);
  endtask

  task automatic xfer(input logic [OW-1:0] opc);
    spi_begin();
    spi_bits({24'h0, opc}, OW);
    spi_end();
  endtask

  task automatic check_drain(input string tag);
    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL %s_pending got=%0d exp=0", tag, exp_q.size());
    end
    total++;
    assert (short_seen == short_exp) else begin
      bad++; $error("FAIL %s_short got=%0d exp=%0d", tag, short_seen, short_exp);
    end
    total++;
    assert (short_seen_l == short_exp) else begin
      bad++; $error("FAIL %s_short_long got=%0d exp=%0d", tag, short_seen_l, short_exp);
    end
  endtask

  task automatic check_opc(input string tag, input logic [OW-1:0] exp);
    total++;
    assert (opc_data === exp) else begin
      bad++; $error("FAIL %s got=%h exp=%h", tag, opc_data, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    spi_cs    = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    cfg_edge  = 1'b0;
    cfg_en    = '0;
    cfg_match = '0;
    cfg_mask  = '0;
    cyc(3);
    check_opc("rst_opc_data", 8'h00);
    total++;
    assert (opc_vld === 1'b0) else begin bad++; $error("FAIL rst_vld got=%b exp=0", opc_vld); end
    total++;
    assert (short_err === 1'b0) else begin bad++; $error("FAIL rst_short got=%b exp=0", short_err); end
    rst_n = 1'b1;
    cyc(10);

    // single channel exact match, mode 0
    set_ch(0, 1'b1, PROGRAM_EXECUTE, 8'hFF);
    push(8'h10, 5'b00001);
    xfer(PROGRAM_EXECUTE);
    cyc(80);
    check_drain("t1");
    check_opc("t1_opc", 8'h10);

    // masked match plus a second channel hitting together
    set_ch(1, 1'b1, READ_STATUS2, 8'hFB);
    set_ch(4, 1'b1, WRITE_STATUS2, 8'hFF);
    push(8'h01, 5'b10010);
    xfer(WRITE_STATUS2);
    cyc(80);
    push(8'h05, 5'b00010);
    xfer(READ_STATUS2);
    cyc(80);
    check_drain("t2");

    // back-to-back same opcode at CLK/4, retriggers the long pulse
    set_ch(3, 1'b1, PAGE_DATA_READ, 8'hFF);
    half = 2;
    push(8'h13, 5'b01000);
    xfer(PAGE_DATA_READ);
    cyc(12);
    push(8'h13, 5'b01000);
    xfer(PAGE_DATA_READ);
    cyc(90);
    half = 4;
    check_drain("t3");

    // short transaction
    spi_begin();
    spi_bits(32'h15, 5);
    spi_end();
    short_exp++;
    cyc(40);
    check_drain("t4");
    check_opc("t4_opc_held", 8'h13);

    // opcode followed by address; config change mid-transaction is shadowed
    set_ch(2, 1'b1, BLOCK_ERASE_128K, 8'hFF);
    push(8'hD8, 5'b00100);
    spi_begin();
    spi_bits(32'hD, 4);
    set_ch(2, 1'b1, 8'h00, 8'hFF);
    set_ch(0, 1'b1, BLOCK_ERASE_128K, 8'hFF);
    spi_bits(32'h8, 4);
    spi_bits(32'h101010, 24);
    spi_end();
    cyc(80);
    push(8'hD8, 5'b00001);
    xfer(BLOCK_ERASE_128K);
    cyc(80);
    check_drain("t5");
    set_ch(0, 1'b1, PROGRAM_EXECUTE, 8'hFF);
    set_ch(2, 1'b1, BLOCK_ERASE_128K, 8'hFF);

    // reset in the middle of an opcode
    spi_begin();
    spi_bits(32'h1, 4);
    rst_n = 1'b0;
    cyc(3);
    check_opc("t6_rst_opc", 8'h00);
    rst_n = 1'b1;
    cyc(2);
    spi_bits(32'h0, 4);
    spi_end();
    cyc(40);
    check_drain("t6a");
    check_opc("t6_no_capture", 8'h00);
    push(8'h10, 5'b00001);
    xfer(PROGRAM_EXECUTE);
    cyc(80);
    check_drain("t6b");

    // falling-edge sampling, mode 3
    cfg_edge = 1'b1;
    spi_clk  = 1'b1;
    cyc(10);
    push(8'h10, 5'b00001);
    xfer(PROGRAM_EXECUTE);
    cyc(80);
    check_drain("t7");
    check_opc("t7_opc", 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
